fetch_stage: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the program counter and drives the byte address into the instruction memory.
- Captures the returned 32-bit word and PC+4 into the IF/ID pipeline register.
- Applies stall, flush and branch redirects from the hazard unit and the ID-stage branch comparator; stops fetching at a programmed end address.

---
 rtl/mips_pkg.sv | 16 +
 rtl/fetch_stage_if.sv | 15 +
 rtl/ifid_reg.sv | 45 ++++
 rtl/fetch_stage.sv | 96 +++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline stages.
//   fetch_state_e : fetch-stage sequencer states
//   PC_STEP       : byte increment between sequential instructions
//   INSTR_W       : instruction word width
//   NOP_WORD_DFLT : default bubble word (sll $0,$0,0)
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [INSTR_W-1:0] NOP_WORD_DFLT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
//   imem_addr        : byte address (driven by fetch)
//   imem_instruction : combinational word returned for imem_addr
// modport master = fetch stage, slave = memory.
interface fetch_stage_if
  import mips_pkg::*;
#(
  parameter int ADDR_W = 7
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instruction;

  modport master (output imem_addr, input  imem_instruction);
  modport slave  (input  imem_addr, output imem_instruction);
endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with load / hold / bubble controls.
//   bubble_i : load NOP_WORD, pc_plus4=0, valid=0 (wins over load_i)
//   load_i   : capture instr_i / pc_plus4_i, valid=1
//   neither  : hold
// Asynchronous active-low reset puts the register into the bubble state.
module ifid_reg
  import mips_pkg::*;
#(
  parameter int                 ADDR_W   = 7,
  parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DFLT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               bubble_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_plus4_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_plus4_o,
  output logic               valid_o
);
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_plus4_q;
  logic               valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= NOP_WORD;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (bubble_i) begin
      instr_q    <= NOP_WORD;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (load_i) begin
      instr_q    <= instr_i;
      pc_plus4_q <= pc_plus4_i;
      valid_q    <= 1'b1;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// address and fills the IF/ID register.
//   imem           : instruction-memory bus (master side)
//   stall / flush  : hazard-unit hold / bubble requests
//   branch_taken   : ID-stage redirect to branch_target (word aligned)
//   ifid_*         : IF/ID register contents
//   halted         : fetch stopped after capturing the word at PROG_END
// Sequencing: BOOT (one edge after reset) -> RUN -> HALT (reset only exit).
module fetch_stage
  import mips_pkg::*;
#(
  parameter int                 ADDR_W   = 7,
  parameter logic [ADDR_W-1:0]  PROG_END = 7'd124,
  parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DFLT
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_stage_if.master      imem,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc_plus4,
  output logic               ifid_valid,
  output logic               halted
);
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;
  logic              load, bubble;
  logic [ADDR_W-1:0] pc_plus4;

  // Modulo 2^ADDR_W: the top word wraps to address 0.
  assign pc_plus4 = pc_q + ADDR_W'(PC_STEP);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    load     = 1'b0;
    bubble   = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (branch_taken) begin
          // Redirect beats stall/flush and also beats a halt at PROG_END.
          pc_d   = branch_target & ~ADDR_W'(3);
          bubble = 1'b1;
        end else if (flush) begin
          bubble = 1'b1;
          if (!stall) pc_d = pc_plus4;
        end else if (!stall) begin
          load = 1'b1;
          // The last instruction is still captured; pc parks on it.
          if (pc_q == PROG_END) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      // Re-loading the bubble every cycle is the same as bubble-then-hold.
      HALT: bubble = 1'b1;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  ifid_reg #(.ADDR_W(ADDR_W), .NOP_WORD(NOP_WORD)) u_ifid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .bubble_i   (bubble),
    .instr_i    (imem.imem_instruction),
    .pc_plus4_i (pc_plus4),
    .instr_o    (ifid_instr),
    .pc_plus4_o (ifid_pc_plus4),
    .valid_o    (ifid_valid)
  );

  assign imem.imem_addr = pc_q;
  assign halted         = halted_q;
endmodule
